// File: rtl/rom_download_if.sv
// ioctl download stream in, SDRAM word port and BRAM byte port out.
// master = download controller, slave = environment (bridge + memories).
interface rom_download_if #(
  parameter int unsigned BRAM_BITS = 16,
  parameter int unsigned SEL_W     = 2
);
  logic                 ioctl_download;
  logic [7:0]           ioctl_index;
  logic                 ioctl_wr;
  logic [24:0]          ioctl_addr;
  logic [7:0]           ioctl_dout;
  logic                 ioctl_wait;
  logic                 sdr_req;
  logic                 sdr_ack;
  logic [23:0]          sdr_addr;
  logic [15:0]          sdr_data;
  logic [1:0]           sdr_be;
  logic                 bram_wr;
  logic [SEL_W-1:0]     bram_sel;
  logic [BRAM_BITS-1:0] bram_addr;
  logic [7:0]           bram_data;
  logic                 rom_ready;
  logic                 load_error;

  modport master (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sdr_ack,
    output ioctl_wait, sdr_req, sdr_addr, sdr_data, sdr_be,
           bram_wr, bram_sel, bram_addr, bram_data, rom_ready, load_error
  );

  modport slave (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, sdr_ack,
    input  ioctl_wait, sdr_req, sdr_addr, sdr_data, sdr_be,
           bram_wr, bram_sel, bram_addr, bram_data, rom_ready, load_error
  );
endinterface

// File: rtl/rom_download_ctrl.sv
// Routes the ioctl ROM download into SDRAM (16-bit words) or on-chip BRAM regions,
// throttling the source with ioctl_wait and flagging rom_ready when fully committed.
module rom_download_ctrl #(
  parameter logic [7:0]  ROM_INDEX  = 8'h00,
  parameter logic [24:0] SDR_LIMIT  = 25'h100000,
  parameter int unsigned BRAM_BITS  = 16,
  parameter int unsigned BRAM_COUNT = 4
) (
  input logic            clk_48,
  input logic            reset,
  rom_download_if.master io
);
  localparam int unsigned SEL_W     = $clog2(BRAM_COUNT);
  localparam logic [24:0] BRAM_SPAN = 25'(BRAM_COUNT) << BRAM_BITS;

  typedef enum logic [2:0] {IDLE, LOAD, SDR_WAIT, FLUSH, DONE} state_t;

  state_t               state, state_nxt;
  logic                 pend_valid, pend_valid_nxt;
  logic [23:0]          pend_word, pend_word_nxt;
  logic [7:0]           pend_byte, pend_byte_nxt;
  logic                 hold_valid, hold_valid_nxt;
  logic [24:0]          hold_addr, hold_addr_nxt;
  logic [7:0]           hold_data, hold_data_nxt;
  logic                 wait_q, wait_nxt;
  logic                 sdr_req, sdr_req_nxt;
  logic [23:0]          sdr_addr, sdr_addr_nxt;
  logic [15:0]          sdr_data, sdr_data_nxt;
  logic [1:0]           sdr_be, sdr_be_nxt;
  logic                 bram_wr, bram_wr_nxt;
  logic [SEL_W-1:0]     bram_sel, bram_sel_nxt;
  logic [BRAM_BITS-1:0] bram_addr, bram_addr_nxt;
  logic [7:0]           bram_data, bram_data_nxt;
  logic                 rom_ready, rom_ready_nxt;
  logic                 load_error, load_error_nxt;

  logic                 rom_start, rom_wr;
  logic [24:0]          dec_addr, dec_off;
  logic [7:0]           dec_data;
  logic                 dec_sdr, dec_bram;

  // Address decode: the live byte, or the held byte while it waits behind a flush
  always_comb begin
    dec_addr = (state == SDR_WAIT) ? hold_addr : io.ioctl_addr;
    dec_data = (state == SDR_WAIT) ? hold_data : io.ioctl_dout;
    dec_off  = dec_addr - SDR_LIMIT;
    dec_sdr  = dec_addr < SDR_LIMIT;
    dec_bram = !dec_sdr && (dec_off < BRAM_SPAN);
  end

  always_comb begin
    state_nxt      = state;
    pend_valid_nxt = pend_valid;
    pend_word_nxt  = pend_word;
    pend_byte_nxt  = pend_byte;
    hold_valid_nxt = hold_valid;
    hold_addr_nxt  = hold_addr;
    hold_data_nxt  = hold_data;
    sdr_req_nxt    = sdr_req;
    sdr_addr_nxt   = sdr_addr;
    sdr_data_nxt   = sdr_data;
    sdr_be_nxt     = sdr_be;
    bram_wr_nxt    = 1'b0;
    bram_sel_nxt   = bram_sel;
    bram_addr_nxt  = bram_addr;
    bram_data_nxt  = bram_data;
    load_error_nxt = load_error;
    rom_start      = io.ioctl_download && (io.ioctl_index == ROM_INDEX);
    rom_wr         = io.ioctl_wr && (io.ioctl_index == ROM_INDEX);

    if (rom_wr && wait_q) load_error_nxt = 1'b1;

    unique case (state)
      IDLE, DONE: begin
        if (rom_start) begin
          state_nxt      = (state == IDLE) ? LOAD : IDLE;
          load_error_nxt = 1'b0;
          pend_valid_nxt = 1'b0;
          hold_valid_nxt = 1'b0;
        end
      end
      LOAD: begin
        if (!io.ioctl_download) begin
          state_nxt = pend_valid ? FLUSH : DONE;
        end else if (rom_wr && !wait_q) begin
          if (dec_sdr && !dec_addr[0]) begin
            if (pend_valid && pend_word != dec_addr[24:1]) begin
              hold_valid_nxt = 1'b1;
              hold_addr_nxt  = dec_addr;
              hold_data_nxt  = dec_data;
              state_nxt      = FLUSH;
            end else begin
              pend_valid_nxt = 1'b1;
              pend_word_nxt  = dec_addr[24:1];
              pend_byte_nxt  = dec_data;
            end
          end else if (dec_sdr) begin
            sdr_req_nxt  = 1'b1;
            sdr_addr_nxt = dec_addr[24:1];
            state_nxt    = SDR_WAIT;
            if (pend_valid && pend_word == dec_addr[24:1]) begin
              sdr_data_nxt   = {dec_data, pend_byte};
              sdr_be_nxt     = 2'b11;
              pend_valid_nxt = 1'b0;
            end else begin
              sdr_data_nxt = {dec_data, 8'h00};
              sdr_be_nxt   = 2'b10;
            end
          end else if (dec_bram) begin
            if (pend_valid) begin
              hold_valid_nxt = 1'b1;
              hold_addr_nxt  = dec_addr;
              hold_data_nxt  = dec_data;
              state_nxt      = FLUSH;
            end else begin
              bram_wr_nxt   = 1'b1;
              bram_sel_nxt  = SEL_W'(dec_off >> BRAM_BITS);
              bram_addr_nxt = dec_off[BRAM_BITS-1:0];
              bram_data_nxt = dec_data;
            end
          end else begin
            load_error_nxt = 1'b1;
          end
        end
      end
      FLUSH: begin
        sdr_req_nxt    = 1'b1;
        sdr_addr_nxt   = pend_word;
        sdr_data_nxt   = {8'h00, pend_byte};
        sdr_be_nxt     = 2'b01;
        pend_valid_nxt = 1'b0;
        state_nxt      = SDR_WAIT;
      end
      SDR_WAIT: begin
        if (io.sdr_ack && sdr_req) begin
          sdr_req_nxt = 1'b0;
          // Flushed slot is free, so the held byte always lands now
          if (hold_valid) begin
            hold_valid_nxt = 1'b0;
            if (dec_bram) begin
              bram_wr_nxt   = 1'b1;
              bram_sel_nxt  = SEL_W'(dec_off >> BRAM_BITS);
              bram_addr_nxt = dec_off[BRAM_BITS-1:0];
              bram_data_nxt = dec_data;
            end else begin
              pend_valid_nxt = 1'b1;
              pend_word_nxt  = dec_addr[24:1];
              pend_byte_nxt  = dec_data;
            end
          end
          if (!io.ioctl_download) state_nxt = pend_valid_nxt ? FLUSH : DONE;
          else                    state_nxt = LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase

    rom_ready_nxt = (state_nxt == DONE);
    wait_nxt      = (state_nxt == SDR_WAIT) || (state_nxt == FLUSH) || hold_valid_nxt ||
                    ((state_nxt == LOAD) && !io.ioctl_download);
  end

  always_ff @(posedge clk_48) begin
    if (reset) begin
      state      <= IDLE;
      pend_valid <= 1'b0;
      pend_word  <= '0;
      pend_byte  <= '0;
      hold_valid <= 1'b0;
      hold_addr  <= '0;
      hold_data  <= '0;
      wait_q     <= 1'b0;
      sdr_req    <= 1'b0;
      sdr_addr   <= '0;
      sdr_data   <= '0;
      sdr_be     <= '0;
      bram_wr    <= 1'b0;
      bram_sel   <= '0;
      bram_addr  <= '0;
      bram_data  <= '0;
      rom_ready  <= 1'b0;
      load_error <= 1'b0;
    end else begin
      state      <= state_nxt;
      pend_valid <= pend_valid_nxt;
      pend_word  <= pend_word_nxt;
      pend_byte  <= pend_byte_nxt;
      hold_valid <= hold_valid_nxt;
      hold_addr  <= hold_addr_nxt;
      hold_data  <= hold_data_nxt;
      wait_q     <= wait_nxt;
      sdr_req    <= sdr_req_nxt;
      sdr_addr   <= sdr_addr_nxt;
      sdr_data   <= sdr_data_nxt;
      sdr_be     <= sdr_be_nxt;
      bram_wr    <= bram_wr_nxt;
      bram_sel   <= bram_sel_nxt;
      bram_addr  <= bram_addr_nxt;
      bram_data  <= bram_data_nxt;
      rom_ready  <= rom_ready_nxt;
      load_error <= load_error_nxt;
    end
  end

  assign io.ioctl_wait = wait_q;
  assign io.sdr_req    = sdr_req;
  assign io.sdr_addr   = sdr_addr;
  assign io.sdr_data   = sdr_data;
  assign io.sdr_be     = sdr_be;
  assign io.bram_wr    = bram_wr;
  assign io.bram_sel   = bram_sel;
  assign io.bram_addr  = bram_addr;
  assign io.bram_data  = bram_data;
  assign io.rom_ready  = rom_ready;
  assign io.load_error = load_error;
endmodule

// File: tb/tb_rom_download_ctrl.sv
// Directed bench for rom_download_ctrl: word packing, flushes, BRAM routing, errors, reset.
module tb_rom_download_ctrl;
  logic clk_48 = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  rom_download_if #(.BRAM_BITS(16), .SEL_W(2)) bus ();

  rom_download_ctrl dut (.clk_48(clk_48), .reset(reset), .io(bus));

  always #10 clk_48 = ~clk_48;

  // Inputs change and outputs are sampled 1 ns after each rising edge
  task automatic tick();
    @(posedge clk_48);
    #1;
  endtask

  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    bus.ioctl_wr   = 1'b1;
    bus.ioctl_addr = a;
    bus.ioctl_dout = d;
    tick();
    bus.ioctl_wr   = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.sdr_ack = 1'b1;
    tick();
    bus.sdr_ack = 1'b0;
  endtask

  task automatic start_dl();
    bus.ioctl_index    = 8'h00;
    bus.ioctl_download = 1'b1;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.ioctl_download = 1'b0;
    bus.ioctl_index = 8'h00;
    bus.ioctl_wr = 1'b0;
    bus.ioctl_addr = '0;
    bus.ioctl_dout = '0;
    bus.sdr_ack = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    n_chk++;
    if ({bus.ioctl_wait, bus.sdr_req, bus.sdr_addr, bus.sdr_data, bus.sdr_be, bus.bram_wr,
         bus.bram_sel, bus.bram_addr, bus.bram_data, bus.rom_ready, bus.load_error} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b wait=%b ready=%b err=%b, want all 0",
               bus.sdr_req, bus.ioctl_wait, bus.rom_ready, bus.load_error);
    end
  endtask

  task automatic test_word_pack();
    start_dl();
    wr_byte(25'h000000, 8'hAA);
    n_chk++;
    if ({bus.sdr_req, bus.ioctl_wait} !== 2'b00) begin
      n_fail++; $display("FAIL even_no_req: got req/wait=%b want 00", {bus.sdr_req, bus.ioctl_wait});
    end
    wr_byte(25'h000001, 8'hBB);
    n_chk++;
    if ({bus.sdr_req, bus.ioctl_wait, bus.sdr_addr, bus.sdr_data, bus.sdr_be} !== {2'b11, 24'h0, 16'hBBAA, 2'b11}) begin
      n_fail++; $display("FAIL word_req: got req=%b wait=%b addr=%h data=%h be=%b want 1 1 000000 bbaa 11",
                         bus.sdr_req, bus.ioctl_wait, bus.sdr_addr, bus.sdr_data, bus.sdr_be);
    end
    tick();
    tick();
    n_chk++;
    if ({bus.sdr_req, bus.ioctl_wait, bus.sdr_data} !== {2'b11, 16'hBBAA}) begin
      n_fail++; $display("FAIL word_hold: got req=%b wait=%b data=%h want 1 1 bbaa", bus.sdr_req, bus.ioctl_wait, bus.sdr_data);
    end
    ack_pulse();
    n_chk++;
    if ({bus.sdr_req, bus.ioctl_wait} !== 2'b00) begin
      n_fail++; $display("FAIL word_ack: got req/wait=%b want 00", {bus.sdr_req, bus.ioctl_wait});
    end
    bus.ioctl_download = 1'b0;
    tick();
    n_chk++;
    if ({bus.rom_ready, bus.sdr_req} !== 2'b10) begin
      n_fail++; $display("FAIL word_done: got ready/req=%b want 10", {bus.rom_ready, bus.sdr_req});
    end
  endtask

  task automatic test_flush();
    start_dl();
    n_chk++;
    if (bus.rom_ready !== 1'b0) begin
      n_fail++; $display("FAIL restart_ready: got %b want 0", bus.rom_ready);
    end
    wr_byte(25'h000010, 8'h11);
    wr_byte(25'h000020, 8'h22);
    n_chk++;
    if ({bus.sdr_req, bus.ioctl_wait} !== 2'b01) begin
      n_fail++; $display("FAIL flush_enter: got req/wait=%b want 01", {bus.sdr_req, bus.ioctl_wait});
    end
    tick();
    n_chk++;
    if ({bus.sdr_req, bus.sdr_addr, bus.sdr_data[7:0], bus.sdr_be} !== {1'b1, 24'h8, 8'h11, 2'b01}) begin
      n_fail++; $display("FAIL flush_req: got req=%b addr=%h lo=%h be=%b want 1 000008 11 01",
                         bus.sdr_req, bus.sdr_addr, bus.sdr_data[7:0], bus.sdr_be);
    end
    ack_pulse();
    n_chk++;
    if ({bus.sdr_req, bus.ioctl_wait} !== 2'b00) begin
      n_fail++; $display("FAIL flush_ack: got req/wait=%b want 00", {bus.sdr_req, bus.ioctl_wait});
    end
    bus.ioctl_download = 1'b0;
    tick();
    n_chk++;
    if ({bus.ioctl_wait, bus.rom_ready} !== 2'b10) begin
      n_fail++; $display("FAIL end_flush_wait: got wait/ready=%b want 10", {bus.ioctl_wait, bus.rom_ready});
    end
    tick();
    n_chk++;
    if ({bus.sdr_req, bus.sdr_addr, bus.sdr_data[7:0], bus.sdr_be} !== {1'b1, 24'h10, 8'h22, 2'b01}) begin
      n_fail++; $display("FAIL end_flush_req: got req=%b addr=%h lo=%h be=%b want 1 000010 22 01",
                         bus.sdr_req, bus.sdr_addr, bus.sdr_data[7:0], bus.sdr_be);
    end
    ack_pulse();
    n_chk++;
    if ({bus.rom_ready, bus.ioctl_wait, bus.sdr_req} !== 3'b100) begin
      n_fail++; $display("FAIL end_flush_done: got ready/wait/req=%b want 100", {bus.rom_ready, bus.ioctl_wait, bus.sdr_req});
    end
  endtask

  task automatic test_odd_and_bram();
    start_dl();
    wr_byte(25'h000005, 8'hCC);
    n_chk++;
    if ({bus.sdr_req, bus.sdr_addr, bus.sdr_data[15:8], bus.sdr_be} !== {1'b1, 24'h2, 8'hCC, 2'b10}) begin
      n_fail++; $display("FAIL odd_req: got req=%b addr=%h hi=%h be=%b want 1 000002 cc 10",
                         bus.sdr_req, bus.sdr_addr, bus.sdr_data[15:8], bus.sdr_be);
    end
    ack_pulse();
    wr_byte(25'h110003, 8'h5A);
    n_chk++;
    if ({bus.bram_wr, bus.bram_sel, bus.bram_addr, bus.bram_data, bus.sdr_req, bus.ioctl_wait} !==
        {1'b1, 2'd1, 16'h0003, 8'h5A, 2'b00}) begin
      n_fail++; $display("FAIL bram_wr: got wr=%b sel=%0d addr=%h data=%h req=%b wait=%b want 1 1 0003 5a 0 0",
                         bus.bram_wr, bus.bram_sel, bus.bram_addr, bus.bram_data, bus.sdr_req, bus.ioctl_wait);
    end
    tick();
    n_chk++;
    if (bus.bram_wr !== 1'b0) begin
      n_fail++; $display("FAIL bram_pulse: got %b want 0", bus.bram_wr);
    end
    wr_byte(25'h140000, 8'h77);
    n_chk++;
    if ({bus.load_error, bus.bram_wr, bus.sdr_req} !== 3'b100) begin
      n_fail++; $display("FAIL out_of_range: got err/bram/req=%b want 100", {bus.load_error, bus.bram_wr, bus.sdr_req});
    end
    bus.ioctl_download = 1'b0;
    tick();
    n_chk++;
    if ({bus.rom_ready, bus.load_error} !== 2'b11) begin
      n_fail++; $display("FAIL err_sticky: got ready/err=%b want 11", {bus.rom_ready, bus.load_error});
    end
  endtask

  task automatic test_wr_during_wait();
    start_dl();
    n_chk++;
    if (bus.load_error !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b want 0", bus.load_error);
    end
    wr_byte(25'h000001, 8'hBB);
    wr_byte(25'h000002, 8'h77);
    n_chk++;
    if ({bus.load_error, bus.sdr_req, bus.sdr_addr} !== {2'b11, 24'h0}) begin
      n_fail++; $display("FAIL wr_in_wait: got err=%b req=%b addr=%h want 1 1 000000", bus.load_error, bus.sdr_req, bus.sdr_addr);
    end
    ack_pulse();
    bus.ioctl_download = 1'b0;
    tick();
    n_chk++;
    if ({bus.rom_ready, bus.ioctl_wait} !== 2'b10) begin
      n_fail++; $display("FAIL dropped_not_pending: got ready/wait=%b want 10", {bus.rom_ready, bus.ioctl_wait});
    end
    bus.ioctl_index = 8'h01;
    bus.ioctl_download = 1'b1;
    tick();
    wr_byte(25'h110000, 8'h99);
    n_chk++;
    if ({bus.rom_ready, bus.bram_wr, bus.sdr_req} !== 3'b100) begin
      n_fail++; $display("FAIL other_index: got ready/bram/req=%b want 100", {bus.rom_ready, bus.bram_wr, bus.sdr_req});
    end
    bus.ioctl_download = 1'b0;
    bus.ioctl_index = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid_req();
    start_dl();
    wr_byte(25'h000003, 8'h44);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_chk++;
    if ({bus.sdr_req, bus.ioctl_wait, bus.rom_ready} !== 3'b000) begin
      n_fail++; $display("FAIL reset_mid_req: got req/wait/ready=%b want 000", {bus.sdr_req, bus.ioctl_wait, bus.rom_ready});
    end
    start_dl();
    wr_byte(25'h000100, 8'h01);
    wr_byte(25'h000101, 8'h02);
    n_chk++;
    if ({bus.sdr_req, bus.sdr_addr, bus.sdr_data, bus.sdr_be} !== {1'b1, 24'h80, 16'h0201, 2'b11}) begin
      n_fail++; $display("FAIL post_reset_req: got req=%b addr=%h data=%h be=%b want 1 000080 0201 11",
                         bus.sdr_req, bus.sdr_addr, bus.sdr_data, bus.sdr_be);
    end
    bus.ioctl_download = 1'b0;
    tick();
    n_chk++;
    if (bus.rom_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_ack: got %b want 0", bus.rom_ready);
    end
    ack_pulse();
    n_chk++;
    if ({bus.rom_ready, bus.ioctl_wait, bus.sdr_req} !== 3'b100) begin
      n_fail++; $display("FAIL post_reset_done: got ready/wait/req=%b want 100", {bus.rom_ready, bus.ioctl_wait, bus.sdr_req});
    end
  endtask

  initial begin
    test_reset();
    test_word_pack();
    test_flush();
    test_odd_and_bram();
    test_wr_during_wait();
    test_reset_mid_req();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
